// File: rtl/matrix_multiplier_seq_if.sv
// Host, control and dual-port memory signals of the matrix multiply engine.
interface matrix_multiplier_seq_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN_LOG = 7
);
   logic                   start;
   logic [MAX_LEN_LOG-1:0] dim_m, dim_k, dim_n;
   logic [ADDR_WIDTH-1:0]  base_a, base_b, base_c;
   logic                   busy, done, error;
   logic [ADDR_WIDTH-1:0]  host_addr;
   logic [DATA_WIDTH-1:0]  host_data_in;
   logic                   host_we;
   logic [DATA_WIDTH-1:0]  host_data_out;
   logic [ADDR_WIDTH-1:0]  mem_addr_a;
   logic [DATA_WIDTH-1:0]  mem_q_a;
   logic [ADDR_WIDTH-1:0]  mem_addr_b;
   logic [DATA_WIDTH-1:0]  mem_data_b;
   logic                   mem_we_b;
   logic [DATA_WIDTH-1:0]  mem_q_b;

   modport master (
      output start, dim_m, dim_k, dim_n, base_a, base_b, base_c,
             host_addr, host_data_in, host_we, mem_q_a, mem_q_b,
      input  busy, done, error, host_data_out,
             mem_addr_a, mem_addr_b, mem_data_b, mem_we_b
   );

   modport slave (
      input  start, dim_m, dim_k, dim_n, base_a, base_b, base_c,
             host_addr, host_data_in, host_we, mem_q_a, mem_q_b,
      output busy, done, error, host_data_out,
             mem_addr_a, mem_addr_b, mem_data_b, mem_we_b
   );
endinterface

// File: rtl/matrix_multiplier_seq.sv
// Sequential C = A x B engine driving ports A and B of a dual-port matrix memory.
// Define MM_SATURATE_EN to clamp written results instead of keeping the low bits.
module matrix_multiplier_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN     = 100,
   parameter int MAX_LEN_LOG = 7
) (
   input logic                    clk,
   input logic                    reset,
   matrix_multiplier_seq_if.slave bus
);
   localparam int ACC_W = 2*DATA_WIDTH + MAX_LEN_LOG;
   localparam logic [MAX_LEN_LOG-1:0] MAX_L = MAX_LEN_LOG'(MAX_LEN);
   localparam logic [MAX_LEN_LOG-1:0] ONE   = MAX_LEN_LOG'(1);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FIN} state_t;

   state_t                  state_q, state_d;
   logic [MAX_LEN_LOG-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
   logic [MAX_LEN_LOG-1:0]  i_q, i_d, j_q, j_d, kc_q, kc_d;
   logic [ADDR_WIDTH-1:0]   ptr_a_q, ptr_a_d, row_a_q, row_a_d;
   logic [ADDR_WIDTH-1:0]   ptr_b_q, ptr_b_d, col_b_q, col_b_d, base_b_q, base_b_d;
   logic [ADDR_WIDTH-1:0]   ptr_c_q, ptr_c_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    done_q, done_d, error_q, error_d;
   logic                    dims_ok, busy;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0]   result;

   assign dims_ok = (bus.dim_m != '0) && (bus.dim_m <= MAX_L) &&
                    (bus.dim_k != '0) && (bus.dim_k <= MAX_L) &&
                    (bus.dim_n != '0) && (bus.dim_n <= MAX_L);

   // Memory data lags the issued address by one cycle, so this is the previous pair.
   assign prod = $signed(bus.mem_q_a) * $signed(bus.mem_q_b);
   assign busy = (state_q == READ) || (state_q == DRAIN) || (state_q == WRITE);

`ifdef MM_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   always_comb begin
      result = acc_q[DATA_WIDTH-1:0];
      if (acc_q > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
      else if (acc_q < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
   end
`else
   assign result = acc_q[DATA_WIDTH-1:0];
`endif

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      k_d      = k_q;
      n_d      = n_q;
      i_d      = i_q;
      j_d      = j_q;
      kc_d     = kc_q;
      ptr_a_d  = ptr_a_q;
      row_a_d  = row_a_q;
      ptr_b_d  = ptr_b_q;
      col_b_d  = col_b_q;
      base_b_d = base_b_q;
      ptr_c_d  = ptr_c_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      error_d  = error_q;
      case (state_q)
         IDLE: if (bus.start) begin
            if (dims_ok) begin
               m_d      = bus.dim_m;
               k_d      = bus.dim_k;
               n_d      = bus.dim_n;
               i_d      = '0;
               j_d      = '0;
               kc_d     = '0;
               ptr_a_d  = bus.base_a;
               row_a_d  = bus.base_a;
               ptr_b_d  = bus.base_b;
               col_b_d  = bus.base_b;
               base_b_d = bus.base_b;
               ptr_c_d  = bus.base_c;
               error_d  = 1'b0;
               state_d  = READ;
            end else begin
               error_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         READ: begin
            acc_d   = (kc_q == '0) ? '0 : acc_q + ACC_W'(prod);
            ptr_a_d = ptr_a_q + ADDR_WIDTH'(1);
            ptr_b_d = ptr_b_q + ADDR_WIDTH'(n_q);
            if (kc_q == k_q - ONE) begin
               kc_d    = '0;
               state_d = DRAIN;
            end else begin
               kc_d = kc_q + ONE;
            end
         end
         DRAIN: begin
            acc_d   = acc_q + ACC_W'(prod);
            state_d = WRITE;
         end
         WRITE: begin
            ptr_c_d = ptr_c_q + ADDR_WIDTH'(1);
            state_d = READ;
            if (j_q == n_q - ONE) begin
               j_d     = '0;
               i_d     = i_q + ONE;
               row_a_d = row_a_q + ADDR_WIDTH'(k_q);
               ptr_a_d = row_a_q + ADDR_WIDTH'(k_q);
               col_b_d = base_b_q;
               ptr_b_d = base_b_q;
               if (i_q == m_q - ONE) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end else begin
               j_d     = j_q + ONE;
               ptr_a_d = row_a_q;
               col_b_d = col_b_q + ADDR_WIDTH'(1);
               ptr_b_d = col_b_q + ADDR_WIDTH'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         m_q      <= '0;
         k_q      <= '0;
         n_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         kc_q     <= '0;
         ptr_a_q  <= '0;
         row_a_q  <= '0;
         ptr_b_q  <= '0;
         col_b_q  <= '0;
         base_b_q <= '0;
         ptr_c_q  <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         k_q      <= k_d;
         n_q      <= n_d;
         i_q      <= i_d;
         j_q      <= j_d;
         kc_q     <= kc_d;
         ptr_a_q  <= ptr_a_d;
         row_a_q  <= row_a_d;
         ptr_b_q  <= ptr_b_d;
         col_b_q  <= col_b_d;
         base_b_q <= base_b_d;
         ptr_c_q  <= ptr_c_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   // Port B belongs to the host whenever the engine is not mid-job.
   always_comb begin
      bus.busy       = busy;
      bus.done       = done_q;
      bus.error      = error_q;
      bus.mem_addr_a = (state_q == READ) ? ptr_a_q : '0;
      if (!busy) begin
         bus.mem_addr_b    = bus.host_addr;
         bus.mem_data_b    = bus.host_data_in;
         bus.mem_we_b      = bus.host_we & ~reset;
         bus.host_data_out = bus.mem_q_b;
      end else begin
         bus.mem_addr_b    = (state_q == WRITE) ? ptr_c_q : ptr_b_q;
         bus.mem_data_b    = result;
         bus.mem_we_b      = (state_q == WRITE);
         bus.host_data_out = '0;
      end
   end
endmodule

// File: tb/tb_matrix_multiplier_seq.sv
// Self-checking bench: dual-port memory model plus a loop-based matrix reference.
module tb_matrix_multiplier_seq;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] mem     [4096] = '{default: 32'h0};
   logic [31:0] exp_mem [4096] = '{default: 32'h0};
   logic [31:0] pre_mem [4096];

   matrix_multiplier_seq_if mif ();

   matrix_multiplier_seq dut (.clk(clk), .reset(reset), .bus(mif));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mif.mem_q_a <= mem[mif.mem_addr_a];
      if (mif.mem_we_b) mem[mif.mem_addr_b] <= mif.mem_data_b;
      mif.mem_q_b <= mem[mif.mem_addr_b];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_mem(input string tag);
      int bad = 0;
      for (int a = 0; a < 4096; a++) if (mem[a] !== exp_mem[a]) bad++;
      chk(tag, 64'(bad), 64'd0);
   endtask

   task automatic host_wr(input int a, input logic [31:0] d);
      @(negedge clk);
      mif.host_addr    = 12'(a);
      mif.host_data_in = d;
      mif.host_we      = 1'b1;
      @(posedge clk);
      #1 mif.host_we = 1'b0;
      exp_mem[a & 4095] = d;
   endtask

   task automatic host_rd(input int a, output logic [31:0] d);
      @(negedge clk);
      mif.host_addr = 12'(a);
      mif.host_we   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      d = mif.host_data_out;
   endtask

   task automatic load_rand(input int base, input int cnt);
      for (int x = 0; x < cnt; x++) host_wr((base + x) & 4095, $urandom);
   endtask

   // Reference: element-by-element in row-major order on the expected memory image,
   // so overlapping regions see earlier C writes exactly as the hardware does.
   task automatic compute_model(input int m, k, n, ba, bb, bc);
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++) begin
            logic signed [79:0] s;
            logic [31:0] r;
            s = '0;
            for (int kk = 0; kk < k; kk++) begin
               longint pa, pb;
               pa = longint'($signed(exp_mem[(ba + i*k + kk) & 4095]));
               pb = longint'($signed(exp_mem[(bb + kk*n + j) & 4095]));
               s  = s + 80'(pa * pb);
            end
`ifdef MM_SATURATE_EN
            if (s > 80'sh7FFFFFFF)       r = 32'h7FFFFFFF;
            else if (s < -80'sh80000000) r = 32'h80000000;
            else                         r = s[31:0];
`else
            r = s[31:0];
`endif
            exp_mem[(bc + i*n + j) & 4095] = r;
         end
   endtask

   task automatic start_job(input int m, k, n, ba, bb, bc);
      @(negedge clk);
      mif.dim_m  = 7'(m);
      mif.dim_k  = 7'(k);
      mif.dim_n  = 7'(n);
      mif.base_a = 12'(ba);
      mif.base_b = 12'(bb);
      mif.base_c = 12'(bc);
      mif.start  = 1'b1;
      @(posedge clk);
      #1 mif.start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int limit,
                            output int dcyc, output int bcyc, output int wcnt);
      dcyc = -1;
      bcyc = 0;
      wcnt = 0;
      for (int c = cyc0 + 1; c <= limit; c++) begin
         @(negedge clk);
         if (mif.busy)     bcyc++;
         if (mif.mem_we_b) wcnt++;
         if (mif.done) begin
            dcyc = c;
            break;
         end
      end
   endtask

   initial begin
      int dc, bc, wc, m, k, n, ba, bb, bcc;
      logic [31:0] rd, c00, v;

      mif.start = 0; mif.dim_m = 0; mif.dim_k = 0; mif.dim_n = 0;
      mif.base_a = 0; mif.base_b = 0; mif.base_c = 0;
      mif.host_addr = 12'd4000; mif.host_data_in = 32'h5555; mif.host_we = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(mif.busy), 64'd0);
      chk("rst_done", 64'(mif.done), 64'd0);
      chk("rst_error", 64'(mif.error), 64'd0);
      chk("rst_we_b", 64'(mif.mem_we_b), 64'd0);
      chk("rst_addr_a", 64'(mif.mem_addr_a), 64'd0);
      mif.host_we = 1'b0;
      @(negedge clk) reset = 1'b0;

      // 2x2 worked example
      host_wr(0, 1); host_wr(1, 2); host_wr(2, 3); host_wr(3, 4);
      host_wr(16, 5); host_wr(17, 6); host_wr(18, 7); host_wr(19, 8);
      compute_model(2, 2, 2, 0, 16, 32);
      start_job(2, 2, 2, 0, 16, 32);
      wait_done(0, 1000, dc, bc, wc);
      chk("t1_done_cyc", 64'(dc), 64'd17);
      chk("t1_busy_cyc", 64'(bc), 64'd16);
      chk("t1_writes", 64'(wc), 64'd4);
      chk("t1_error", 64'(mif.error), 64'd0);
      chk("t1_c0", 64'(mem[32]), 64'd19);
      chk("t1_c1", 64'(mem[33]), 64'd22);
      chk("t1_c2", 64'(mem[34]), 64'd43);
      chk("t1_c3", 64'(mem[35]), 64'd50);
      chk_mem("t1_mem");

      // Illegal dimensions: K=0 then N=101
      start_job(2, 0, 2, 0, 16, 60);
      wait_done(0, 50, dc, bc, wc);
      chk("t3a_done_cyc", 64'(dc), 64'd1);
      chk("t3a_busy", 64'(bc), 64'd0);
      chk("t3a_writes", 64'(wc), 64'd0);
      chk("t3a_error", 64'(mif.error), 64'd1);
      start_job(2, 2, 101, 0, 16, 60);
      wait_done(0, 50, dc, bc, wc);
      chk("t3b_done_cyc", 64'(dc), 64'd1);
      chk("t3b_busy", 64'(bc), 64'd0);
      chk("t3b_writes", 64'(wc), 64'd0);
      repeat (3) @(negedge clk);
      chk("t3_error_sticky", 64'(mif.error), 64'd1);
      chk("t3_done_low", 64'(mif.done), 64'd0);
      chk_mem("t3_mem");

      // Identity times B; the accepted start also clears the sticky error
      for (int x = 0; x < 9; x++) host_wr(100 + x, (x % 4 == 0) ? 32'd1 : 32'd0);
      for (int x = 0; x < 9; x++) host_wr(120 + x, 32'(x + 1));
      compute_model(3, 3, 3, 100, 120, 140);
      start_job(3, 3, 3, 100, 120, 140);
      chk("t2_error_cleared", 64'(mif.error), 64'd0);
      wait_done(0, 1000, dc, bc, wc);
      chk("t2_busy_cyc", 64'(bc), 64'd45);
      chk("t2_done_cyc", 64'(dc), 64'd46);
      for (int x = 0; x < 9; x++) chk($sformatf("t2_c%0d", x), 64'(mem[140 + x]), 64'(x + 1));
      chk_mem("t2_mem");

      // 1x1x1 full-scale product
      host_wr(200, 32'h7FFFFFFF); host_wr(201, 32'h7FFFFFFF);
      compute_model(1, 1, 1, 200, 201, 202);
      start_job(1, 1, 1, 200, 201, 202);
      wait_done(0, 100, dc, bc, wc);
      chk("t4_done_cyc", 64'(dc), 64'd4);
`ifdef MM_SATURATE_EN
      chk("t4_c", 64'(mem[202]), 64'h7FFFFFFF);
`else
      chk("t4_c", 64'(mem[202]), 64'h00000001);
`endif

      // Sum beyond 2^63: four (-2^31)^2 terms
      for (int x = 0; x < 4; x++) host_wr(210 + x, 32'h80000000);
      for (int x = 0; x < 4; x++) host_wr(220 + x, 32'h80000000);
      compute_model(1, 4, 1, 210, 220, 230);
      start_job(1, 4, 1, 210, 220, 230);
      wait_done(0, 100, dc, bc, wc);
`ifdef MM_SATURATE_EN
      chk("t4b_c", 64'(mem[230]), 64'h7FFFFFFF);
`else
      chk("t4b_c", 64'(mem[230]), 64'h00000000);
`endif
      chk_mem("t4_mem");

      // Largest legal K
      load_rand(300, 100);
      load_rand(400, 200);
      compute_model(1, 100, 2, 300, 400, 700);
      start_job(1, 100, 2, 300, 400, 700);
      wait_done(0, 1000, dc, bc, wc);
      chk("tmax_done_cyc", 64'(dc), 64'd205);
      chk_mem("tmax_mem");

      // Host writes while busy are blocked and reads return zero
      load_rand(800, 6);
      load_rand(820, 8);
      compute_model(3, 2, 4, 800, 820, 840);
      start_job(3, 2, 4, 800, 820, 840);
      repeat (3) @(negedge clk);
      mif.host_addr = 12'd40; mif.host_data_in = 32'hDEADBEEF; mif.host_we = 1'b1;
      chk("t5_hdo_zero", 64'(mif.host_data_out), 64'd0);
      @(negedge clk);
      @(negedge clk) mif.host_we = 1'b0;
      wait_done(5, 1000, dc, bc, wc);
      chk("t5_done_cyc", 64'(dc), 64'd49);
      chk("t5_mem40", 64'(mem[40]), 64'(exp_mem[40]));
      for (int x = 0; x < 12; x += 5) begin
         host_rd(840 + x, rd);
         chk($sformatf("t5_hrd%0d", x), 64'(rd), 64'(exp_mem[840 + x]));
      end
      chk_mem("t5_mem");

      // Reset 10 cycles into a 4x4x4 job
      load_rand(500, 16);
      load_rand(520, 16);
      pre_mem = exp_mem;
      compute_model(4, 4, 4, 500, 520, 540);
      c00 = exp_mem[540];
      start_job(4, 4, 4, 500, 520, 540);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6_busy", 64'(mif.busy), 64'd0);
      chk("t6_done", 64'(mif.done), 64'd0);
      @(negedge clk) reset = 1'b0;
      chk("t6_c00_kept", 64'(mem[540]), 64'(c00));
      chk("t6_c01_untouched", 64'(mem[541]), 64'(pre_mem[541]));
      exp_mem = pre_mem;
      exp_mem[540] = c00;
      v = $urandom;
      host_wr(50, v);
      host_rd(50, rd);
      chk("t6_host_rdback", 64'(rd), 64'(v));
      compute_model(4, 4, 4, 500, 520, 540);
      start_job(4, 4, 4, 500, 520, 540);
      wait_done(0, 1000, dc, bc, wc);
      chk("t6_done_cyc", 64'(dc), 64'd97);
      chk_mem("t6_mem");

      // Random jobs with wrapping/overlapping regions; one gets a start mid-job
      for (int t = 0; t < 5; t++) begin
         m = $urandom_range(1, 5); k = $urandom_range(1, 5); n = $urandom_range(1, 5);
         ba = $urandom_range(0, 4095); bb = $urandom_range(0, 4095);
         bcc = (t == 2) ? ba : $urandom_range(0, 4095);
         load_rand(ba, m*k);
         load_rand(bb, k*n);
         compute_model(m, k, n, ba, bb, bcc);
         start_job(m, k, n, ba, bb, bcc);
         if (t == 1) begin
            repeat (2) @(negedge clk);
            mif.dim_m = 7'd1; mif.dim_k = 7'd1; mif.dim_n = 7'd1; mif.start = 1'b1;
            @(posedge clk);
            #1 mif.start = 1'b0;
            wait_done(2, 2000, dc, bc, wc);
         end else begin
            wait_done(0, 2000, dc, bc, wc);
         end
         chk($sformatf("rnd%0d_done_cyc", t), 64'(dc), 64'(m*n*(k+2) + 1));
         chk($sformatf("rnd%0d_writes", t), 64'(wc), 64'(m*n));
         chk_mem($sformatf("rnd%0d_mem", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
